// File: rtl/rr_arb8.sv
// rr_arb8 -- eight-way round-robin arbiter with a bounded grant tenure.
//
// A grant is issued from IDLE to the first active requester found by a
// circular search starting at ptr. The owner keeps the grant until it
// pulses rel, drops its request, or has held the grant for MAX_HOLD
// cycles. Every tenure is followed by one dead GAP cycle. ptr then moves
// to the slot after the previous owner, so continuously active requesters
// are served in strict rotation.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req      request lines, bit i = requester i
//   rel      owner's release pulse (named rel because release is a
//            reserved word); ignored outside a tenure
//   gnt_idx  binary index of the current or most recent owner
//   gnt_en   high while a grant is active
//   gnt      one-hot grant, decoded from gnt_idx, all zero when gnt_en=0
//   timeout  one-cycle pulse in GAP when the hold limit revoked the grant
module rr_arb8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       rel,
  output logic [2:0] gnt_idx,
  output logic       gnt_en,
  output logic [7:0] gnt,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  state_t     state, state_next;
  logic [2:0] ptr, ptr_next;
  logic [2:0] idx_next;
  logic       en_next;
  logic       to_next;
  logic [7:0] hold, hold_next;

  logic [2:0] pick;
  logic       pick_vld;
  logic [2:0] cand;
  logic       at_lim;
  logic       end_busy;

  // Circular priority search starting at ptr; the 3-bit add wraps 7 -> 0.
  always_comb begin
    pick     = ptr;
    pick_vld = 1'b0;
    cand     = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      cand = ptr + 3'(k);
      if (!pick_vld && req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  assign at_lim   = (hold == HOLD_LIM);
  assign end_busy = rel || !req[gnt_idx] || at_lim;

  // State register together with the registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt_idx <= '0;
      gnt_en  <= 1'b0;
      timeout <= 1'b0;
      hold    <= '0;
    end else begin
      state   <= state_next;
      ptr     <= ptr_next;
      gnt_idx <= idx_next;
      gnt_en  <= en_next;
      timeout <= to_next;
      hold    <= hold_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    idx_next   = gnt_idx;
    en_next    = gnt_en;
    hold_next  = hold;
    to_next    = 1'b0;
    case (state)
      IDLE: begin
        if (req != '0) begin
          state_next = BUSY;
          idx_next   = pick;
          en_next    = 1'b1;
          hold_next  = '0;
        end
      end
      BUSY: begin
        if (end_busy) begin
          state_next = GAP;
          en_next    = 1'b0;
          ptr_next   = gnt_idx + 3'd1;
          // A release or dropped request takes precedence over the limit.
          to_next    = at_lim && !rel && req[gnt_idx];
        end else begin
          // Not at the limit here, so this never passes HOLD_LIM.
          hold_next = hold + 8'd1;
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        en_next    = 1'b0;
      end
    endcase
  end

  // Output decode.
  always_comb begin
    gnt = '0;
    if (gnt_en) gnt = 8'd1 << gnt_idx;
  end

endmodule

// File: doc/rr_arb8.md
RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 Parameter: MAX_HOLD, default 16, is the maximum number of consecutive cycles one requester SHALL hold a grant (legal range 2..255).
REQ-002 Port: clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst_n  input  1  is the asynchronous, active-low reset.
REQ-004 Port: req  input  8  carries the request lines; bit i SHALL be requester i.
REQ-005 Port: release  input  1  is a pulse from the current owner ending its tenure.
REQ-006 Port: gnt_idx  output  3  SHALL carry the binary index of the current owner.
REQ-007 Port: gnt_en  output  1  SHALL be high while a grant is active.
REQ-008 Port: gnt  output  8  SHALL be the one-hot grant, equal to the 3-to-8 decode of gnt_idx when gnt_en=1 and 8'b0 when gnt_en=0.
REQ-009 Port: timeout  output  1  SHALL be a one-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, BUSY and GAP.
REQ-011 IDLE with req!=0 SHALL move to BUSY at the next edge.
REQ-012 On that IDLE-to-BUSY edge: gnt_idx <= first i with req[i]=1, searching circularly from ptr upward; gnt_en <= 1; hold counter <= 0.
REQ-013 IDLE with req==0 SHALL stay in IDLE with gnt_en=0 and gnt_idx unchanged.
REQ-014 In BUSY the hold counter SHALL increment by 1 each cycle, saturating at MAX_HOLD-1.
REQ-015 BUSY SHALL end at the next edge if any of these holds: release=1; req[gnt_idx]=0; hold counter == MAX_HOLD-1.
REQ-016 On the edge that ends BUSY: state <= GAP; gnt_en <= 0; ptr <= (gnt_idx+1) mod 8, wrapping 7 to 0.
REQ-017 timeout SHALL pulse for one cycle (the first GAP cycle) only when BUSY ended solely because hold counter == MAX_HOLD-1, with release=0 and req[gnt_idx]=1.
REQ-018 If release and the limit occur in the same cycle, release SHALL take priority and timeout SHALL stay 0.
REQ-019 GAP SHALL last exactly one cycle, with gnt=0, then move to IDLE.
REQ-020 The worst-case gap between successive grants SHALL therefore be 2 cycles: GAP, then IDLE evaluation.
REQ-021 Grant latency from a request asserted in IDLE SHALL be 1 cycle.
REQ-022 Changes on req during BUSY SHALL NOT alter gnt_idx.
REQ-023 release asserted in IDLE or GAP SHALL be ignored.
REQ-024 gnt SHALL be driven combinationally from the registered gnt_idx and gnt_en, with no extra latency.
REQ-025 Fairness: with all 8 requesters continuously active, grants SHALL cycle 0,1,...,7,0 with no requester skipped.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, force: state=IDLE; ptr=0; gnt_idx=0; gnt_en=0; gnt=8'b0; timeout=0; hold counter=0.
REQ-027 Reset asserted mid-BUSY SHALL drop the grant asynchronously; after deassertion, arbitration SHALL restart from ptr=0.
REQ-028 The first arbitration after rst_n deasserts SHALL occur at the first rising clk edge.

Verification
REQ-029 Scenario, single requester after reset: req=8'h08 -> one cycle later gnt_idx=3, gnt=8'h08, gnt_en=1; then release pulse -> next cycle gnt=0 (GAP).
REQ-030 Scenario, round robin: req=8'hFF, release pulsed every 3rd cycle -> grant order is 0,1,2,...,7,0.
REQ-031 Scenario, wrap with sparse requests: ptr=6 and req=8'h05 -> the grant goes to 0, then to 2.
REQ-032 Scenario, hold limit: MAX_HOLD=4, req=8'h02 held high, no release -> gnt=8'h02 for exactly 4 cycles, then timeout=1 for one cycle with gnt=0, then re-grant to 1.
REQ-033 Scenario, limit/release collision: release=1 in the same cycle the counter reaches 3 (MAX_HOLD=4) -> timeout stays 0.
REQ-034 Scenario, async reset mid-BUSY: rst_n driven low between clock edges while gnt=8'h20 -> gnt=0 before the next edge; after release of reset with req=8'h21, the grant goes to 0.
